// File: rtl/blk_sched.sv
// blk_sched: write-side sequencer for the block-threshold buffer.
// Turns vs_i/de_i timing into block coordinates and save strobes, and keeps
// malformed frames (long/short lines, extra lines, early vsync) away from the
// accumulator array. Every output is registered: outputs at t+1 describe the
// inputs sampled at t.
module blk_sched #(
   parameter int HBLKS  = 10,
   parameter int VBLKS  = 10,
   parameter int HBLK_W = 64,
   parameter int VBLK_H = 64
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     vs_i,
   input  logic                     de_i,
   input  logic [7:0]               wd_i,
   output logic                     de_o,
   output logic [7:0]               wd_o,
   output logic [$clog2(HBLKS)-1:0] ht_o,
   output logic [$clog2(VBLKS)-1:0] vt_o,
   output logic                     h_save_o,
   output logic                     v_save_o,
   output logic                     vs_o,
   output logic                     err_o
);

   localparam int HW = $clog2(HBLKS);
   localparam int VW = $clog2(VBLKS);
   localparam int PW = (HBLK_W > 1) ? $clog2(HBLK_W) : 1;
   localparam int LW = (VBLK_H > 1) ? $clog2(VBLK_H) : 1;

   localparam logic [PW-1:0] PX_LAST = PW'(HBLK_W - 1);
   localparam logic [HW-1:0] HT_LAST = HW'(HBLKS - 1);
   localparam logic [LW-1:0] LN_LAST = LW'(VBLK_H - 1);
   localparam logic [VW-1:0] VT_LAST = VW'(VBLKS - 1);

   // Edge-detect history
   logic          vs_q, de_q;
   // Position counters and frame-status flags
   logic [PW-1:0] px_q, px_d;
   logic [HW-1:0] ht_q, ht_d;
   logic [LW-1:0] ln_q, ln_d;
   logic [VW-1:0] vt_q, vt_d;
   logic          hovf_q, hovf_d;           // line has run past its last block
   logic          line_full_q, line_full_d; // last block of the line was saved
   logic          row_done_q, row_done_d;   // final row committed; block until vs
   logic          abort_q, abort_d;         // line cut by vs; ignore rest of it
   logic          err_acc_q, err_acc_d;     // malformation seen in this frame
   logic          seen_q, seen_d;           // a frame start has happened since reset
   // Output registers
   logic          de_d, h_save_d, v_save_d, vs_o_d, err_o_d;
   logic [7:0]    wd_d;
   logic [HW-1:0] ht_o_d;
   logic [VW-1:0] vt_o_d;

   logic vs_rise, de_fall, in_range;

   assign vs_rise  = vs_i & ~vs_q;
   assign de_fall  = de_q & ~de_i;
   assign in_range = ~hovf_q & ~row_done_q & ~abort_q;

   // Next-state and output decode; frame start has priority over line end
   always_comb begin
      px_d        = px_q;
      ht_d        = ht_q;
      ln_d        = ln_q;
      vt_d        = vt_q;
      hovf_d      = hovf_q;
      line_full_d = line_full_q;
      row_done_d  = row_done_q;
      abort_d     = abort_q;
      err_acc_d   = err_acc_q;
      seen_d      = seen_q;
      de_d        = 1'b0;
      h_save_d    = 1'b0;
      v_save_d    = 1'b0;
      vs_o_d      = 1'b0;
      err_o_d     = err_o;
      wd_d        = wd_i;
      ht_o_d      = ht_o;
      vt_o_d      = vt_o;

      if (vs_rise) begin
         vs_o_d      = 1'b1;
         // Report only frames that had a proper start; a frame is good when the
         // last row was committed and nothing else went wrong.
         err_o_d     = seen_q & (err_acc_q | ~row_done_q | (ln_q != '0));
         seen_d      = 1'b1;
         px_d        = '0;
         ht_d        = '0;
         ln_d        = '0;
         vt_d        = '0;
         hovf_d      = 1'b0;
         line_full_d = 1'b0;
         row_done_d  = 1'b0;
         abort_d     = de_i;
         err_acc_d   = de_i;
      end else if (de_i) begin
         if (in_range) begin
            de_d   = 1'b1;
            ht_o_d = ht_q;
            vt_o_d = vt_q;
            if (px_q == PX_LAST) begin
               h_save_d = 1'b1;
               px_d     = '0;
               if (ht_q == HT_LAST) begin
                  hovf_d      = 1'b1;
                  line_full_d = 1'b1;
               end else begin
                  ht_d = ht_q + 1'b1;
               end
            end else begin
               px_d = px_q + 1'b1;
            end
         end else if (!abort_q) begin
            err_acc_d = 1'b1;
         end
      end else if (de_fall) begin
         px_d        = '0;
         ht_d        = '0;
         hovf_d      = 1'b0;
         line_full_d = 1'b0;
         if (abort_q) begin
            abort_d = 1'b0;
         end else if (row_done_q) begin
            err_acc_d = 1'b1;
         end else begin
            if (!line_full_q) err_acc_d = 1'b1;
            if (ln_q == LN_LAST) begin
               v_save_d = 1'b1;
               vt_o_d   = vt_q;
               ln_d     = '0;
               if (vt_q == VT_LAST) row_done_d = 1'b1;
               else                 vt_d       = vt_q + 1'b1;
            end else begin
               ln_d = ln_q + 1'b1;
            end
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vs_q        <= 1'b0;
         de_q        <= 1'b0;
         px_q        <= '0;
         ht_q        <= '0;
         ln_q        <= '0;
         vt_q        <= '0;
         hovf_q      <= 1'b0;
         line_full_q <= 1'b0;
         row_done_q  <= 1'b0;
         abort_q     <= 1'b0;
         err_acc_q   <= 1'b0;
         seen_q      <= 1'b0;
         de_o        <= 1'b0;
         wd_o        <= '0;
         ht_o        <= '0;
         vt_o        <= '0;
         h_save_o    <= 1'b0;
         v_save_o    <= 1'b0;
         vs_o        <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         vs_q        <= vs_i;
         de_q        <= de_i;
         px_q        <= px_d;
         ht_q        <= ht_d;
         ln_q        <= ln_d;
         vt_q        <= vt_d;
         hovf_q      <= hovf_d;
         line_full_q <= line_full_d;
         row_done_q  <= row_done_d;
         abort_q     <= abort_d;
         err_acc_q   <= err_acc_d;
         seen_q      <= seen_d;
         de_o        <= de_d;
         wd_o        <= wd_d;
         ht_o        <= ht_o_d;
         vt_o        <= vt_o_d;
         h_save_o    <= h_save_d;
         v_save_o    <= v_save_d;
         vs_o        <= vs_o_d;
         err_o       <= err_o_d;
      end
   end

endmodule

// File: tb/tb_blk_sched.sv
// tb_blk_sched: directed bench for blk_sched with 2x2 blocks of 4 px x 2 lines.
module tb_blk_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       vs = 1'b0;
   logic       de = 1'b0;
   logic [7:0] wd = 8'd0;
   logic       de_o, h_save_o, v_save_o, vs_o, err_o;
   logic [7:0] wd_o;
   logic       ht_o, vt_o;

   int n_chk  = 0;
   int n_pass = 0;

   blk_sched #(.HBLKS(2), .VBLKS(2), .HBLK_W(4), .VBLK_H(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .vs_i(vs), .de_i(de), .wd_i(wd),
      .de_o(de_o), .wd_o(wd_o), .ht_o(ht_o), .vt_o(vt_o),
      .h_save_o(h_save_o), .v_save_o(v_save_o), .vs_o(vs_o), .err_o(err_o)
   );

   // clock
   always #5 clk = ~clk;

   // advance one clock; outputs then describe the inputs held before the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      de = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   // one active line of npx pixels; allow=0 means the row is already committed
   task automatic do_line(input string nm, input int npx, input bit allow,
                          input bit exp_vs, input logic exp_vt);
      bit   exp_de;
      logic exp_ht;
      for (int i = 0; i < npx; i++) begin
         de = 1'b1;
         wd = 8'(8'h10 + i);
         step();
         exp_de = allow && (i < 8);
         exp_ht = 1'((i / 4) & 1);
         n_chk++;
         if (de_o !== exp_de || h_save_o !== (exp_de && (i % 4 == 3)) || wd_o !== wd ||
             v_save_o !== 1'b0 || (exp_de && ht_o !== exp_ht))
            $display("FAIL %s px%0d: de_o=%b h_save_o=%b wd_o=%h ht_o=%b v_save_o=%b, want de_o=%b h_save_o=%b wd_o=%h ht_o=%b v_save_o=0",
                     nm, i, de_o, h_save_o, wd_o, ht_o, v_save_o, exp_de,
                     exp_de && (i % 4 == 3), wd, exp_ht);
         else n_pass++;
      end
      de = 1'b0;
      step();
      n_chk++;
      if (v_save_o !== exp_vs || de_o !== 1'b0 || h_save_o !== 1'b0 || (exp_vs && vt_o !== exp_vt))
         $display("FAIL %s line_end: v_save_o=%b vt_o=%b de_o=%b h_save_o=%b, want v_save_o=%b vt_o=%b de_o=0 h_save_o=0",
                  nm, v_save_o, vt_o, de_o, h_save_o, exp_vs, exp_vt);
      else n_pass++;
      step();
      n_chk++;
      if (v_save_o !== 1'b0)
         $display("FAIL %s v_save_width: v_save_o=%b, want 0", nm, v_save_o);
      else n_pass++;
      idle(1);
   endtask

   // vsync rising edge with de low; err_o reports the frame just ended
   task automatic do_vs(input string nm, input bit exp_err);
      vs = 1'b1;
      step();
      n_chk++;
      if (vs_o !== 1'b1 || v_save_o !== 1'b0 || err_o !== exp_err)
         $display("FAIL %s vs_edge: vs_o=%b v_save_o=%b err_o=%b, want vs_o=1 v_save_o=0 err_o=%b",
                  nm, vs_o, v_save_o, err_o, exp_err);
      else n_pass++;
      step();
      n_chk++;
      if (vs_o !== 1'b0 || err_o !== exp_err)
         $display("FAIL %s vs_hold: vs_o=%b err_o=%b, want vs_o=0 err_o=%b", nm, vs_o, err_o, exp_err);
      else n_pass++;
      vs = 1'b0;
      idle(2);
   endtask

   task automatic clean_frame(input string nm);
      do_line(nm, 8, 1'b1, 1'b0, 1'b0);
      do_line(nm, 8, 1'b1, 1'b1, 1'b0);
      do_line(nm, 8, 1'b1, 1'b0, 1'b0);
      do_line(nm, 8, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
      // two pixels, then reset while de is high
      for (int i = 0; i < 2; i++) begin de = 1'b1; wd = 8'hA5; step(); end
      rst_n = 1'b0;
      step();
      n_chk++;
      if ({de_o, wd_o, ht_o, vt_o, h_save_o, v_save_o, vs_o, err_o} !== 15'd0)
         $display("FAIL reset_outputs: de_o=%b wd_o=%h ht_o=%b vt_o=%b h_save_o=%b v_save_o=%b vs_o=%b err_o=%b, want all 0",
                  de_o, wd_o, ht_o, vt_o, h_save_o, v_save_o, vs_o, err_o);
      else n_pass++;
      rst_n = 1'b1;
      step();
      idle(2);
      do_vs("reset_first_vs", 1'b0);
   endtask

   task automatic test_clean();
      clean_frame("clean");
      do_vs("clean_vs", 1'b0);
   endtask

   task automatic test_long_line();
      do_line("long", 10, 1'b1, 1'b0, 1'b0);
      do_line("long", 8, 1'b1, 1'b1, 1'b0);
      do_line("long", 8, 1'b1, 1'b0, 1'b0);
      do_line("long", 8, 1'b1, 1'b1, 1'b1);
      do_vs("long_vs", 1'b1);
   endtask

   task automatic test_short_line();
      do_line("short", 6, 1'b1, 1'b0, 1'b0);
      do_line("short", 8, 1'b1, 1'b1, 1'b0);
      do_line("short", 8, 1'b1, 1'b0, 1'b0);
      do_line("short", 8, 1'b1, 1'b1, 1'b1);
      do_vs("short_vs", 1'b1);
   endtask

   task automatic test_extra_line();
      clean_frame("extra");
      do_line("extra5", 8, 1'b0, 1'b0, 1'b0);
      do_vs("extra_vs", 1'b1);
   endtask

   task automatic test_partial_frame();
      do_line("partial", 8, 1'b1, 1'b0, 1'b0);
      do_line("partial", 8, 1'b1, 1'b1, 1'b0);
      do_line("partial", 8, 1'b1, 1'b0, 1'b0);
      do_vs("partial_vs", 1'b1);
      clean_frame("recover");
      do_vs("recover_vs", 1'b0);
   endtask

   task automatic test_vs_at_de_fall();
      do_line("sim", 8, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin de = 1'b1; wd = 8'(i); step(); end
      de = 1'b0;
      vs = 1'b1;
      step();
      n_chk++;
      if (vs_o !== 1'b1 || v_save_o !== 1'b0 || err_o !== 1'b1)
         $display("FAIL sim_edge: vs_o=%b v_save_o=%b err_o=%b, want vs_o=1 v_save_o=0 err_o=1",
                  vs_o, v_save_o, err_o);
      else n_pass++;
      step();
      n_chk++;
      if (v_save_o !== 1'b0 || vs_o !== 1'b0)
         $display("FAIL sim_after: v_save_o=%b vs_o=%b, want 0 0", v_save_o, vs_o);
      else n_pass++;
      vs = 1'b0;
      idle(2);
      clean_frame("sim_next");
      do_vs("sim_next_vs", 1'b0);
   endtask

   task automatic test_vs_mid_line();
      for (int i = 0; i < 3; i++) begin de = 1'b1; wd = 8'(i); step(); end
      vs = 1'b1;
      step();
      n_chk++;
      if (vs_o !== 1'b1 || de_o !== 1'b0 || h_save_o !== 1'b0)
         $display("FAIL abort_edge: vs_o=%b de_o=%b h_save_o=%b, want 1 0 0", vs_o, de_o, h_save_o);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         step();
         n_chk++;
         if (de_o !== 1'b0 || h_save_o !== 1'b0)
            $display("FAIL abort_px%0d: de_o=%b h_save_o=%b, want 0 0", i, de_o, h_save_o);
         else n_pass++;
      end
      de = 1'b0;
      step();
      n_chk++;
      if (v_save_o !== 1'b0)
         $display("FAIL abort_end: v_save_o=%b, want 0", v_save_o);
      else n_pass++;
      vs = 1'b0;
      idle(2);
      clean_frame("abort_frame");
      do_vs("abort_vs", 1'b1);
   endtask

   initial begin
      test_reset();
      test_clean();
      test_long_line();
      test_short_line();
      test_extra_line();
      test_partial_frame();
      test_vs_at_de_fall();
      test_vs_mid_line();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
